pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- MUL_LAT, 4: multiply busy cycles.
- DIV_LAT, 32: divide busy cycles.
- CNT_W, 16: stall counter width.

REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, in, 1: single clock, all state on rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- stall_IF_ID, in, 1: hazard unit stall request.
- flush_IF, in, 1: hazard unit IF flush request.
- mem_req, in, 1: MEM-stage load/store present.
- mem_ready, in, 1: data memory completes the access this cycle.
- ex_md_op, in, 2: EX-stage op; 00 none, 01 mult, 10 div, 11 reserved (treated as none).
- pc_en, out, 1: PC write enable.
- if_id_en, out, 1: IF/ID register enable.
- id_ex_en, out, 1: ID/EX register enable.
- ex_mem_en, out, 1: EX/MEM register enable.
- if_id_flush, out, 1: IF/ID bubble.
- id_ex_flush, out, 1: ID/EX bubble.
- ex_mem_flush, out, 1: EX/MEM bubble.
- mem_wb_flush, out, 1: MEM/WB bubble.
- md_start, out, 1: one-cycle start pulse to mult/div unit.
- md_done, out, 1: HI/LO result valid, write this cycle.
- stall_cnt, out, CNT_W: saturating count of cycles with pc_en=0.

Function
REQ-003 SHALL define mem_freeze = mem_req & ~mem_ready and md_freeze = (state==MD_IDLE & op is mult/div) | state==MD_RUN; all outputs below are combinational from state and inputs.
REQ-004 SHALL apply priority mem_freeze > md_freeze > stall_IF_ID > flush_IF; only the highest active condition drives outputs.
REQ-005 SHALL, on mem_freeze: pc_en, if_id_en, id_ex_en, ex_mem_en=0; mem_wb_flush=1; other flushes=0.
REQ-006 SHALL, on md_freeze: pc_en, if_id_en, id_ex_en=0; ex_mem_en=1; ex_mem_flush=1; other flushes=0.
REQ-007 SHALL, on stall_IF_ID: pc_en, if_id_en=0; id_ex_flush=1; flush_IF ignored (the branch re-resolves next cycle).
REQ-008 SHALL, on flush_IF alone: all enables=1; if_id_flush=1.
REQ-009 SHALL, when no condition is active: all enables=1; all flushes=0.
REQ-010 SHALL implement FSM MD_IDLE, MD_RUN, MD_DONE with a down-counter wide enough for DIV_LAT-1.
REQ-011 SHALL, in MD_IDLE with a mult/div op and no mem_freeze: assert md_start; load the counter with MUL_LAT-1 or DIV_LAT-1; go to MD_RUN.
REQ-012 SHALL, in MD_IDLE with mem_freeze: hold MD_IDLE and keep md_start=0.
REQ-013 SHALL, in MD_RUN: decrement the counter every cycle regardless of mem_freeze; at counter==0, go to MD_DONE.
REQ-014 SHALL, in MD_DONE: assert md_done; if no mem_freeze, return to MD_IDLE while the EX instruction advances; if mem_freeze, hold MD_DONE with md_done asserted.
REQ-015 SHALL freeze a mult/div in EX for LAT+1 cycles; the instruction leaves EX at the end of cycle LAT+2.
REQ-016 SHALL increment stall_cnt on every cycle with pc_en=0 and saturate at 2^CNT_W-1.

Reset
REQ-017 SHALL, when rst_n=0 at a clock edge: state=MD_IDLE, counter=0, stall_cnt=0.
REQ-018 SHALL, while rst_n=0: force all enables=1, all flushes=1, md_start=0, md_done=0, independent of other inputs.
REQ-019 SHALL, on reset asserted mid-MD_RUN: abandon the operation with no md_done pulse.

Structure
REQ-020 SHALL place the md_op encoding, the FSM state encoding, and the MUL_LAT/DIV_LAT defaults in shared package pipeline_pkg.
REQ-021 SHALL implement stall_cnt as sub-module sat_counter (enable, synchronous active-low clear, width parameter).

Verification
REQ-022 SHALL cover: ex_md_op=01 for one idle cycle -> md_start high 1 cycle, ex_mem_flush high 5 cycles, md_done in cycle 6, stall_cnt=5.
REQ-023 SHALL cover: ex_md_op=10 -> md_done exactly 33 cycles after md_start; pc_en low 33 cycles.
REQ-024 SHALL cover: mem_req=1, mem_ready=0 for 3 cycles then 1 -> ex_mem_en=0 and mem_wb_flush=1 for 3 cycles, all enables 1 in cycle 4.
REQ-025 SHALL cover: stall_IF_ID=1 with flush_IF=1 -> if_id_flush=0, id_ex_flush=1, pc_en=0; next cycle flush_IF alone -> if_id_flush=1.
REQ-026 SHALL cover: mem_freeze asserted in MD_DONE for 2 cycles -> md_done held 3 cycles, then MD_IDLE.
REQ-027 SHALL cover: rst_n=0 during MD_RUN at counter=10 -> MD_IDLE next cycle, no md_done; stall_cnt forced to 2^CNT_W-1 stays saturated.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   md_op_e    : EX-stage multiply/divide opcode encoding
//   md_state_e : multiply/divide sequencer states
//   MUL_LAT_DEF / DIV_LAT_DEF : default busy-cycle counts
//   md_cnt_width() : bit width of the busy down-counter
package pipeline_pkg;

    localparam int unsigned MUL_LAT_DEF = 4;
    localparam int unsigned DIV_LAT_DEF = 32;

    typedef enum logic [1:0] {
        MD_OP_NONE = 2'b00,
        MD_OP_MUL  = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_RSVD = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    // Width able to hold max(mul_lat, div_lat) - 1, never narrower than 1 bit.
    function automatic int unsigned md_cnt_width(input int unsigned mul_lat,
                                                 input int unsigned div_lat);
        int unsigned m;
        m = (mul_lat > div_lat) ? mul_lat : div_lat;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-unit / pipeline-register control bundle.
//   master : hazard/memory side; drives requests, receives enables/flushes
//   slave  : pipeline_ctrl; receives requests, drives enables/flushes
// Requests : stall_IF_ID, flush_IF, mem_req, mem_ready, ex_md_op
// Controls : pc_en, if_id_en, id_ex_en, ex_mem_en, *_flush, md_start,
//            md_done, stall_cnt[CNT_W]
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import pipeline_pkg::*;

    logic             stall_IF_ID;
    logic             flush_IF;
    logic             mem_req;
    logic             mem_ready;
    md_op_e           ex_md_op;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic             md_start;
    logic             md_done;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output stall_IF_ID, flush_IF, mem_req, mem_ready, ex_md_op,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               md_start, md_done, stall_cnt
    );

    modport slave (
        input  stall_IF_ID, flush_IF, mem_req, mem_ready, ex_md_op,
        output pc_en, if_id_en, id_ex_en, ex_mem_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               md_start, md_done, stall_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter.
//   clk     : rising-edge clock
//   i_clr_n : synchronous active-low clear
//   i_en    : count enable
//   o_count : current count, sticks at all-ones
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             i_clr_n,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with multiply/divide busy sequencer.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : pipeline_ctrl_if.slave (hazard requests in, register
//           enables/flushes, md_start/md_done and stall_cnt out)
// Priority of freeze sources: memory wait > mult/div busy > load-use stall
// > IF flush. Outputs are combinational from the sequencer state and inputs.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF,
    parameter int unsigned CNT_W   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pipeline_ctrl_if.slave bus
);

    localparam int unsigned      LAT_W    = md_cnt_width(MUL_LAT, DIV_LAT);
    localparam logic [LAT_W-1:0] MUL_LOAD = LAT_W'(MUL_LAT - 1);
    localparam logic [LAT_W-1:0] DIV_LOAD = LAT_W'(DIV_LAT - 1);

    md_state_e        r_state;
    logic [LAT_W-1:0] r_lat_cnt;

    logic w_op_md;
    logic w_mem_freeze;
    logic w_md_freeze;
    logic w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en;
    logic w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_mem_wb_flush;
    logic w_md_start, w_md_done;
    logic [CNT_W-1:0] w_stall_cnt;

    assign w_op_md      = (bus.ex_md_op == MD_OP_MUL) || (bus.ex_md_op == MD_OP_DIV);
    assign w_mem_freeze = bus.mem_req & ~bus.mem_ready;
    assign w_md_freeze  = ((r_state == MD_IDLE) && w_op_md) || (r_state == MD_RUN);

    // Busy sequencer. The down-counter keeps running under a memory wait so
    // the unit's fixed latency is honoured; only MD_IDLE and MD_DONE wait.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= MD_IDLE;
            r_lat_cnt <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (w_op_md && !w_mem_freeze) begin
                        r_state   <= MD_RUN;
                        r_lat_cnt <= (bus.ex_md_op == MD_OP_DIV) ? DIV_LOAD : MUL_LOAD;
                    end
                end
                MD_RUN: begin
                    if (r_lat_cnt == '0) begin
                        r_state <= MD_DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end
                end
                MD_DONE: begin
                    if (!w_mem_freeze) begin
                        r_state <= MD_IDLE;
                    end
                end
                default: begin
                    r_state <= MD_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_pc_en        = 1'b1;
        w_if_id_en     = 1'b1;
        w_id_ex_en     = 1'b1;
        w_ex_mem_en    = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_mem_wb_flush = 1'b0;
        w_md_start     = 1'b0;
        w_md_done      = 1'b0;
        if (!rst_n) begin
            // Reset clocks bubbles into every stage regardless of requests.
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_flush = 1'b1;
            w_mem_wb_flush = 1'b1;
        end else begin
            w_md_start = (r_state == MD_IDLE) && w_op_md && !w_mem_freeze;
            w_md_done  = (r_state == MD_DONE);
            if (w_mem_freeze) begin
                w_pc_en        = 1'b0;
                w_if_id_en     = 1'b0;
                w_id_ex_en     = 1'b0;
                w_ex_mem_en    = 1'b0;
                w_mem_wb_flush = 1'b1;
            end else if (w_md_freeze) begin
                // EX holds; EX/MEM keeps loading bubbles behind it.
                w_pc_en        = 1'b0;
                w_if_id_en     = 1'b0;
                w_id_ex_en     = 1'b0;
                w_ex_mem_flush = 1'b1;
            end else if (bus.stall_IF_ID) begin
                // A pending IF flush is dropped; the branch re-resolves.
                w_pc_en       = 1'b0;
                w_if_id_en    = 1'b0;
                w_id_ex_flush = 1'b1;
            end else if (bus.flush_IF) begin
                w_if_id_flush = 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .i_clr_n (rst_n),
        .i_en    (~w_pc_en),
        .o_count (w_stall_cnt)
    );

    assign bus.pc_en        = w_pc_en;
    assign bus.if_id_en     = w_if_id_en;
    assign bus.id_ex_en     = w_id_ex_en;
    assign bus.ex_mem_en    = w_ex_mem_en;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_flush  = w_id_ex_flush;
    assign bus.ex_mem_flush = w_ex_mem_flush;
    assign bus.mem_wb_flush = w_mem_wb_flush;
    assign bus.md_start     = w_md_start;
    assign bus.md_done      = w_md_done;
    assign bus.stall_cnt    = w_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a priority table plus hand-written
// multi-cycle sequences. Expected outputs are queued when stimulus is driven
// and compared when the outputs are sampled on the falling edge.
module tb_pipeline_ctrl;
    import pipeline_pkg::*;

    localparam int unsigned      CNT_W   = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en,
    //  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, md_start, md_done}
    localparam logic [9:0] E_RST   = 10'b1111_1111_00;
    localparam logic [9:0] E_NORM  = 10'b1111_0000_00;
    localparam logic [9:0] E_FLUSH = 10'b1111_1000_00;
    localparam logic [9:0] E_STALL = 10'b0011_0100_00;
    localparam logic [9:0] E_MEM   = 10'b0000_0001_00;
    localparam logic [9:0] E_MD    = 10'b0001_0010_00;
    localparam logic [9:0] B_START = 10'b0000_0000_10;
    localparam logic [9:0] B_DONE  = 10'b0000_0000_01;

    typedef struct packed {
        logic   rst_n;
        logic   stall;
        logic   flush;
        logic   mem_req;
        logic   mem_ready;
        md_op_e op;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [9:0] exp;
        string      name;
    } vec_t;

    typedef struct {
        logic [9:0]       outs;
        logic [CNT_W-1:0] cnt;
        string            name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(
        .MUL_LAT (4),
        .DIV_LAT (32),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];
    logic [CNT_W-1:0] model_cnt = '0;
    int cyc = 0;
    int n_pc_low, n_start, n_exf, n_done, start_cyc, done_cyc;

    function automatic stim_t mk(input logic r, input logic st, input logic fl,
                                 input logic mr, input logic my, input md_op_e op);
        stim_t s;
        s.rst_n = r; s.stall = st; s.flush = fl;
        s.mem_req = mr; s.mem_ready = my; s.op = op;
        return s;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr_tally();
        n_pc_low = 0; n_start = 0; n_exf = 0; n_done = 0;
        start_cyc = -1; done_cyc = -1;
    endtask

    // One clock cycle: drive, queue expectation, sample at negedge, compare.
    task automatic step(input stim_t s, input logic [9:0] e, input string nm);
        exp_t x;
        logic [9:0] act;
        rst_n           = s.rst_n;
        bus.stall_IF_ID = s.stall;
        bus.flush_IF    = s.flush;
        bus.mem_req     = s.mem_req;
        bus.mem_ready   = s.mem_ready;
        bus.ex_md_op    = s.op;
        x.outs = e; x.cnt = model_cnt; x.name = nm;
        sb_q.push_back(x);
        @(negedge clk);
        act = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
               bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush,
               bus.md_start, bus.md_done};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            x = sb_q.pop_front();
            if (act !== x.outs) begin
                errors++;
                $display("FAIL %s outs: got %b expected %b (cycle %0d)", x.name, act, x.outs, cyc);
            end
            checks++;
            if (bus.stall_cnt !== x.cnt) begin
                errors++;
                $display("FAIL %s stall_cnt: got %0d expected %0d", x.name, bus.stall_cnt, x.cnt);
            end
        end
        if (!bus.pc_en)       n_pc_low++;
        if (bus.ex_mem_flush) n_exf++;
        if (bus.md_start) begin n_start++; start_cyc = cyc; end
        if (bus.md_done)  begin n_done++;  done_cyc  = cyc; end
        if (!s.rst_n)                         model_cnt = '0;
        else if (!e[9] && model_cnt != CNT_MAX) model_cnt = model_cnt + CNT_W'(1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    vec_t tbl[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{mk(0, 1, 1, 1, 0, MD_OP_MUL),  E_RST,   "rst_forced"};
        tbl[1]  = '{mk(1, 0, 0, 0, 0, MD_OP_NONE), E_NORM,  "idle"};
        tbl[2]  = '{mk(1, 0, 1, 0, 0, MD_OP_NONE), E_FLUSH, "flush_only"};
        tbl[3]  = '{mk(1, 1, 0, 0, 0, MD_OP_NONE), E_STALL, "stall_only"};
        tbl[4]  = '{mk(1, 1, 1, 0, 0, MD_OP_NONE), E_STALL, "stall_over_flush"};
        tbl[5]  = '{mk(1, 0, 0, 1, 1, MD_OP_NONE), E_NORM,  "mem_ready"};
        tbl[6]  = '{mk(1, 0, 0, 1, 0, MD_OP_NONE), E_MEM,   "mem_wait"};
        tbl[7]  = '{mk(1, 1, 1, 1, 0, MD_OP_NONE), E_MEM,   "mem_over_stall"};
        tbl[8]  = '{mk(1, 0, 0, 1, 0, MD_OP_MUL),  E_MEM,   "mem_over_mul"};
        tbl[9]  = '{mk(1, 1, 0, 1, 0, MD_OP_DIV),  E_MEM,   "mem_over_div"};
        tbl[10] = '{mk(1, 0, 0, 0, 0, MD_OP_RSVD), E_NORM,  "op_reserved"};
        tbl[11] = '{mk(1, 0, 1, 0, 0, MD_OP_RSVD), E_FLUSH, "rsvd_flush"};
        tbl[12] = '{mk(0, 0, 0, 1, 0, MD_OP_DIV),  E_RST,   "rst_forced2"};
        tbl[13] = '{mk(1, 0, 0, 0, 0, MD_OP_NONE), E_NORM,  "idle_after_rst"};

        rst_n = 1'b0;
        bus.stall_IF_ID = 1'b0; bus.flush_IF = 1'b0;
        bus.mem_req = 1'b0; bus.mem_ready = 1'b0; bus.ex_md_op = MD_OP_NONE;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall_cnt", int'(bus.stall_cnt), 0);

        for (int unsigned i = 0; i < 14; i++) step(tbl[i].s, tbl[i].exp, tbl[i].name);

        // Multiply: 5 frozen cycles, result in cycle 6.
        step(mk(0, 0, 0, 0, 0, MD_OP_NONE), E_RST, "mul_pre_rst");
        clr_tally();
        step(mk(1, 0, 0, 0, 0, MD_OP_MUL), E_MD | B_START, "mul_start");
        for (int i = 0; i < 4; i++) step(mk(1, 0, 0, 0, 0, MD_OP_MUL), E_MD, "mul_run");
        step(mk(1, 0, 0, 0, 0, MD_OP_MUL), E_NORM | B_DONE, "mul_done");
        chk("mul_stall_cnt", int'(bus.stall_cnt), 5);
        chk("mul_start_pulses", n_start, 1);
        chk("mul_exmem_flush_cycles", n_exf, 5);
        step(mk(1, 0, 0, 0, 0, MD_OP_NONE), E_NORM, "mul_after");

        // Divide: 33 frozen cycles, md_done 33 cycles after md_start.
        clr_tally();
        step(mk(1, 0, 0, 0, 0, MD_OP_DIV), E_MD | B_START, "div_start");
        for (int i = 0; i < 32; i++) step(mk(1, 0, 0, 0, 0, MD_OP_DIV), E_MD, "div_run");
        step(mk(1, 0, 0, 0, 0, MD_OP_DIV), E_NORM | B_DONE, "div_done");
        chk("div_pc_low_cycles", n_pc_low, 33);
        chk("div_start_to_done", done_cyc - start_cyc, 33);
        step(mk(1, 0, 0, 0, 0, MD_OP_NONE), E_NORM, "div_after");

        // Memory wait for 3 cycles.
        for (int i = 0; i < 3; i++) step(mk(1, 0, 0, 1, 0, MD_OP_NONE), E_MEM, "mem_wait3");
        step(mk(1, 0, 0, 1, 1, MD_OP_NONE), E_NORM, "mem_complete");

        // Stall suppresses IF flush, then flush alone.
        step(mk(1, 1, 1, 0, 0, MD_OP_NONE), E_STALL, "stall_flush");
        step(mk(1, 0, 1, 0, 0, MD_OP_NONE), E_FLUSH, "flush_next");

        // Memory wait mid-run does not stretch the multiply.
        step(mk(1, 0, 0, 0, 0, MD_OP_MUL), E_MD | B_START, "mulm_start");
        step(mk(1, 0, 0, 0, 0, MD_OP_MUL), E_MD, "mulm_run");
        step(mk(1, 0, 0, 1, 0, MD_OP_MUL), E_MEM, "mulm_run_memwait");
        step(mk(1, 0, 0, 0, 0, MD_OP_MUL), E_MD, "mulm_run");
        step(mk(1, 0, 0, 0, 0, MD_OP_MUL), E_MD, "mulm_run");
        step(mk(1, 0, 0, 0, 0, MD_OP_MUL), E_NORM | B_DONE, "mulm_done");

        // Memory wait during MD_DONE holds md_done.
        clr_tally();
        step(mk(1, 0, 0, 0, 0, MD_OP_MUL), E_MD | B_START, "muld_start");
        for (int i = 0; i < 4; i++) step(mk(1, 0, 0, 0, 0, MD_OP_MUL), E_MD, "muld_run");
        for (int i = 0; i < 2; i++) step(mk(1, 0, 0, 1, 0, MD_OP_MUL), E_MEM | B_DONE, "muld_done_hold");
        step(mk(1, 0, 0, 1, 1, MD_OP_MUL), E_NORM | B_DONE, "muld_done_release");
        step(mk(1, 0, 0, 0, 0, MD_OP_NONE), E_NORM, "muld_idle");
        chk("muld_done_cycles", n_done, 3);

        // Saturation: another divide pushes the counter past its maximum.
        step(mk(1, 0, 0, 0, 0, MD_OP_DIV), E_MD | B_START, "sat_div_start");
        for (int i = 0; i < 32; i++) step(mk(1, 0, 0, 0, 0, MD_OP_DIV), E_MD, "sat_div_run");
        step(mk(1, 0, 0, 0, 0, MD_OP_DIV), E_NORM | B_DONE, "sat_div_done");
        chk("stall_cnt_saturated", int'(bus.stall_cnt), int'(CNT_MAX));
        for (int i = 0; i < 3; i++) step(mk(1, 1, 0, 0, 0, MD_OP_NONE), E_STALL, "sat_stall");
        chk("stall_cnt_stays_sat", int'(bus.stall_cnt), int'(CNT_MAX));

        // Reset mid-divide at counter==10 abandons the operation.
        clr_tally();
        step(mk(1, 0, 0, 0, 0, MD_OP_DIV), E_MD | B_START, "abort_start");
        for (int i = 0; i < 21; i++) step(mk(1, 0, 0, 0, 0, MD_OP_DIV), E_MD, "abort_run");
        chk("abort_pre_rst_sat", int'(bus.stall_cnt), int'(CNT_MAX));
        step(mk(0, 0, 0, 0, 0, MD_OP_DIV), E_RST, "abort_rst");
        for (int i = 0; i < 3; i++) step(mk(1, 0, 0, 0, 0, MD_OP_NONE), E_NORM, "abort_idle");
        chk("abort_no_done", n_done, 0);
        step(mk(1, 0, 0, 0, 0, MD_OP_MUL), E_MD | B_START, "abort_restart");
        for (int i = 0; i < 4; i++) step(mk(1, 0, 0, 0, 0, MD_OP_MUL), E_MD, "abort_restart_run");
        step(mk(1, 0, 0, 0, 0, MD_OP_MUL), E_NORM | B_DONE, "abort_restart_done");
        step(mk(1, 0, 0, 0, 0, MD_OP_NONE), E_NORM, "final_idle");

        chk("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
